// File: rtl/replace_way_ctrl.sv
// Victim-selection controller for a 2-way, FIFO-replaced cache: reads a set's pointer, offers the victim, writes back ~victim.
// Optional build macro REPLACE_INVALID_FIRST_EN: prefer the lowest-numbered invalid way over the FIFO pointer.
//
// state   | meaning
// IDLE    | ready to accept a miss
// RD      | captured set presented to the pointer buffer
// SEL     | victim offered, waiting for the consumer
// WB_WAIT | dirty victim taken, waiting for writeback completion
// UPD     | one-cycle pointer write of ~victim
module replace_way_ctrl #(
  parameter int SET_W = 7,
  parameter int CNT_W = 16
) (
  input  logic             fire,
  input  logic             rstn,
  input  logic             i_miss_valid,
  input  logic [SET_W-1:0] i_miss_set,
  input  logic [1:0]       i_way_valid,
  input  logic [1:0]       i_way_dirty,
  output logic             o_miss_ready,
  output logic [SET_W-1:0] o_rb_addr_7,
  output logic             o_rb_write_enable,
  output logic             o_rb_data_in,
  input  logic             i_rb_data_out,
  output logic             o_victim_valid,
  output logic [SET_W-1:0] o_victim_set,
  output logic             o_victim_way,
  output logic             o_victim_dirty,
  input  logic             i_victim_ready,
  input  logic             i_wb_done,
  output logic [CNT_W-1:0] o_evict_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_SEL     = 3'd2;
  localparam logic [2:0] S_WB_WAIT = 3'd3;
  localparam logic [2:0] S_UPD     = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [1:0]       valid_q, valid_d;
  logic [1:0]       dirty_q, dirty_d;
  logic             ptr_q, ptr_d;
  logic             ptr_vld_q, ptr_vld_d;
  logic             way_q, way_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ptr_cur;
  logic             sel_way;
  logic             sel_dirty;

  // The buffer output is only guaranteed on the first SEL cycle; later SEL cycles use the latched copy.
  always_comb begin
    ptr_cur   = ptr_vld_q ? ptr_q : i_rb_data_out;
    sel_way   = ptr_cur;
    sel_dirty = dirty_q[ptr_cur] & valid_q[ptr_cur];
`ifdef REPLACE_INVALID_FIRST_EN
    if (!valid_q[0]) begin
      sel_way   = 1'b0;
      sel_dirty = 1'b0;
    end else if (!valid_q[1]) begin
      sel_way   = 1'b1;
      sel_dirty = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    set_d     = set_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    ptr_d     = ptr_q;
    ptr_vld_d = ptr_vld_q;
    way_d     = way_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_miss_valid) begin
          set_d   = i_miss_set;
          valid_d = i_way_valid;
          dirty_d = i_way_dirty;
          state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = S_SEL;
      end
      S_SEL: begin
        ptr_d     = ptr_cur;
        ptr_vld_d = 1'b1;
        if (i_victim_ready) begin
          way_d     = sel_way;
          ptr_vld_d = 1'b0;
          if (sel_dirty) begin
            state_d = S_WB_WAIT;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_UPD;
          end
        end
      end
      S_WB_WAIT: begin
        if (i_wb_done) begin
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge fire or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      set_q     <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      ptr_q     <= 1'b0;
      ptr_vld_q <= 1'b0;
      way_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      ptr_q     <= ptr_d;
      ptr_vld_q <= ptr_vld_d;
      way_q     <= way_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    o_miss_ready      = (state_q == S_IDLE);
    o_rb_addr_7       = set_q;
    o_rb_write_enable = (state_q == S_UPD);
    o_rb_data_in      = (state_q == S_UPD) & ~way_q;
    o_victim_valid    = (state_q == S_SEL);
    o_victim_set      = set_q;
    o_victim_way      = (state_q == S_SEL) & sel_way;
    o_victim_dirty    = (state_q == S_SEL) & sel_dirty;
    o_evict_cnt       = cnt_q;
  end

endmodule

// File: tb/tb_replace_way_ctrl.sv
// Bench for replace_way_ctrl: directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_replace_way_ctrl;
  localparam int SET_W = 7;
  localparam int CNT_W = 16;

  logic             fire = 1'b0;
  logic             rstn = 1'b0;
  logic             miss_valid = 1'b0;
  logic [SET_W-1:0] miss_set = '0;
  logic [1:0]       way_valid = '0;
  logic [1:0]       way_dirty = '0;
  logic             victim_ready = 1'b0;
  logic             wb_done = 1'b0;

  logic             miss_ready;
  logic [SET_W-1:0] rb_addr;
  logic             rb_we;
  logic             rb_din;
  logic             rb_dout;
  logic             victim_valid;
  logic [SET_W-1:0] victim_set;
  logic             victim_way;
  logic             victim_dirty;
  logic [CNT_W-1:0] evict_cnt;

  int errors = 0;
  int checks = 0;

  replace_way_ctrl #(.SET_W(SET_W), .CNT_W(CNT_W)) dut (
    .fire(fire), .rstn(rstn),
    .i_miss_valid(miss_valid), .i_miss_set(miss_set),
    .i_way_valid(way_valid), .i_way_dirty(way_dirty),
    .o_miss_ready(miss_ready),
    .o_rb_addr_7(rb_addr), .o_rb_write_enable(rb_we),
    .o_rb_data_in(rb_din), .i_rb_data_out(rb_dout),
    .o_victim_valid(victim_valid), .o_victim_set(victim_set),
    .o_victim_way(victim_way), .o_victim_dirty(victim_dirty),
    .i_victim_ready(victim_ready), .i_wb_done(wb_done),
    .o_evict_cnt(evict_cnt)
  );

  always #5 fire = ~fire;

  // Replacement-state buffer: registered read, resets to all zeros.
  logic buf_mem [0:(1<<SET_W)-1];
  always @(posedge fire or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < (1 << SET_W); i++) buf_mem[i] <= 1'b0;
      rb_dout <= 1'b0;
    end else begin
      if (rb_we) buf_mem[rb_addr] <= rb_din;
      rb_dout <= buf_mem[rb_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one miss in flight, described by its age and handshake/writeback flags.
  bit               m_ptr [1<<SET_W];
  bit               m_busy = 0;
  int               m_age = 0;
  logic [SET_W-1:0] m_set = '0;
  bit               m_way = 0, m_vdirty = 0, m_hs = 0, m_wb = 0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic model_reset();
    foreach (m_ptr[i]) m_ptr[i] = 0;
    m_busy = 0; m_age = 0; m_set = '0; m_way = 0; m_vdirty = 0;
    m_hs = 0; m_wb = 0; m_cnt = '0;
  endtask

  always @(negedge fire) begin
    bit exp_vv, exp_we;
    if (!rstn) model_reset();
    exp_vv = m_busy && (m_age >= 2) && !m_hs;
    exp_we = m_busy && m_hs && (!m_vdirty || m_wb);
    chk("miss_ready", miss_ready, !m_busy);
    chk("victim_valid", victim_valid, exp_vv);
    chk("rb_write_enable", rb_we, exp_we);
    chk("rb_addr", rb_addr, m_set);
    chk("rb_data_in", rb_din, exp_we ? !m_way : 1'b0);
    chk("evict_cnt", evict_cnt, m_cnt);
    if (exp_vv) begin
      chk("victim_set", victim_set, m_set);
      chk("victim_way", victim_way, m_way);
      chk("victim_dirty", victim_dirty, m_vdirty);
    end
    if (!rstn) begin
      chk("rst_victim_set", victim_set, 0);
      chk("rst_victim_way", victim_way, 0);
      chk("rst_victim_dirty", victim_dirty, 0);
    end else if (!m_busy) begin
      if (miss_valid) begin
        bit p;
        p = m_ptr[miss_set];
        m_busy = 1; m_age = 1; m_hs = 0; m_wb = 0;
        m_set = miss_set;
        m_way = p;
        m_vdirty = way_dirty[p] & way_valid[p];
`ifdef REPLACE_INVALID_FIRST_EN
        if (way_valid != 2'b11) begin
          m_way = way_valid[0] ? 1'b1 : 1'b0;
          m_vdirty = 0;
        end
`endif
      end
    end else begin
      if (exp_we) begin
        m_ptr[m_set] = !m_way;
        m_busy = 0;
      end else if (exp_vv) begin
        if (victim_ready) begin
          m_hs = 1;
          if (m_vdirty && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
      end else if (m_hs && m_vdirty && wb_done) begin
        m_wb = 1;
      end
      m_age++;
    end
  end

  task automatic tick();
    @(posedge fire);
    #1;
  endtask

  // Issue one miss from IDLE with the consumer always ready; returns the offered victim.
  task automatic run_miss(input logic [SET_W-1:0] s, input logic [1:0] va, input logic [1:0] di,
                          input int wb_delay, output logic way, output logic vd);
    int n;
    miss_valid = 1'b1; miss_set = s; way_valid = va; way_dirty = di;
    tick();
    miss_valid = 1'b0; victim_ready = 1'b1;
    n = 0;
    @(negedge fire);
    while (!victim_valid && n < 20) begin
      tick();
      @(negedge fire);
      n++;
    end
    chk("victim_latency", n, 1);
    way = victim_way;
    vd = victim_dirty;
    tick();
    victim_ready = 1'b0;
    if (vd) begin
      for (int k = 0; k < wb_delay; k++) begin
        @(negedge fire);
        chk("no_write_before_wb", rb_we, 0);
        tick();
      end
      wb_done = 1'b1;
      @(negedge fire);
      chk("no_write_on_wb", rb_we, 0);
      tick();
      wb_done = 1'b0;
    end
    @(negedge fire);
    chk("upd_we", rb_we, 1);
    chk("upd_addr", rb_addr, s);
    chk("upd_din", rb_din, !way);
    tick();
  endtask

  initial begin
    logic w, d;
    logic [SET_W-1:0] s0;
    logic w0, d0;
    int n;

    tick();
    @(negedge fire);
    chk("reset_ready", miss_ready, 1);
    chk("reset_cnt", evict_cnt, 0);
    chk("reset_addr", rb_addr, 0);
    tick();
    rstn = 1'b1;

    // Clean miss on set 0x05, pointer 0
    run_miss(7'h05, 2'b11, 2'b00, 0, w, d);
    chk("t1_way", w, 0);
    chk("t1_dirty", d, 0);
    chk("t1_buf", buf_mem[7'h05], 1);
    chk("t1_cnt", evict_cnt, 0);
    @(negedge fire);
    chk("t1_ready_again", miss_ready, 1);

    // Back-to-back on the same set
    run_miss(7'h05, 2'b11, 2'b00, 0, w, d);
    chk("t2_way", w, 1);
    chk("t2_buf", buf_mem[7'h05], 0);

    // Dirty victim on set 0x7F with pointer 1
    run_miss(7'h7F, 2'b11, 2'b00, 0, w, d);
    chk("t3_pre_way", w, 0);
    run_miss(7'h7F, 2'b11, 2'b10, 5, w, d);
    chk("t3_way", w, 1);
    chk("t3_dirty", d, 1);
    chk("t3_cnt", evict_cnt, 1);
    chk("t3_buf", buf_mem[7'h7F], 0);

    // Consumer stalls for 3 cycles while another request waits
    miss_valid = 1'b1; miss_set = 7'h22; way_valid = 2'b11; way_dirty = 2'b01;
    tick();
    miss_set = 7'h33; victim_ready = 1'b0;
    tick();
    @(negedge fire);
    s0 = victim_set; w0 = victim_way; d0 = victim_dirty;
    chk("t4_vv", victim_valid, 1);
    chk("t4_set", s0, 7'h22);
    chk("t4_way", w0, 0);
    chk("t4_dirty", d0, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge fire);
      chk("t4_hold_vv", victim_valid, 1);
      chk("t4_hold_set", victim_set, s0);
      chk("t4_hold_way", victim_way, w0);
      chk("t4_hold_dirty", victim_dirty, d0);
      chk("t4_not_ready", miss_ready, 0);
    end
    tick();
    victim_ready = 1'b1;
    tick();
    victim_ready = 1'b0; miss_valid = 1'b0; wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    @(negedge fire);
    chk("t4_upd_we", rb_we, 1);
    chk("t4_upd_addr", rb_addr, 7'h22);
    chk("t4_cnt", evict_cnt, 2);
    tick();

    // Invalid way present, pointer 0
    run_miss(7'h10, 2'b01, 2'b00, 0, w, d);
`ifdef REPLACE_INVALID_FIRST_EN
    chk("t5_way", w, 1);
    chk("t5_buf", buf_mem[7'h10], 0);
`else
    chk("t5_way", w, 0);
    chk("t5_buf", buf_mem[7'h10], 1);
`endif
    chk("t5_dirty", d, 0);

    // Reset while waiting for writeback
    miss_valid = 1'b1; miss_set = 7'h40; way_valid = 2'b11; way_dirty = 2'b11;
    tick();
    miss_valid = 1'b0; victim_ready = 1'b1;
    tick();
    tick();
    victim_ready = 1'b0;
    tick();
    rstn = 1'b0;
    @(negedge fire);
    chk("t6_ready", miss_ready, 1);
    chk("t6_we", rb_we, 0);
    chk("t6_addr", rb_addr, 0);
    chk("t6_cnt", evict_cnt, 0);
    chk("t6_buf", buf_mem[7'h05], 0);
    tick();
    rstn = 1'b1;
    miss_valid = 1'b1; miss_set = 7'h41; way_valid = 2'b11; way_dirty = 2'b00;
    tick();
    miss_valid = 1'b0; victim_ready = 1'b1;
    @(negedge fire);
    chk("t6_accepted", miss_ready, 0);
    n = 0;
    while (!miss_ready && n < 20) begin
      tick();
      @(negedge fire);
      n++;
    end
    chk("t6_done_timeout", miss_ready, 1);
    chk("t6_buf41", buf_mem[7'h41], 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      miss_valid   = ($urandom_range(0, 1) == 1);
      miss_set     = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
      way_valid    = 2'($urandom_range(0, 3));
      way_dirty    = 2'($urandom_range(0, 3));
      victim_ready = ($urandom_range(0, 9) < 6);
      wb_done      = ($urandom_range(0, 3) == 0);
    end
    tick();
    miss_valid = 1'b0; victim_ready = 1'b1; wb_done = 1'b1;
    n = 0;
    @(negedge fire);
    while ((!miss_ready || m_busy) && n < 50) begin
      tick();
      @(negedge fire);
      n++;
    end
    chk("drain_timeout", miss_ready, 1);
    for (int i = 0; i < (1 << SET_W); i++) chk("final_ptr", buf_mem[i], m_ptr[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
